// File: rtl/gcd_batch_seq_if.sv
// gcd_batch_seq_if - bundles every non-clock/reset signal of gcd_batch_seq.
//   start                       batch request
//   mem_ena/mem_addr/mem_dout   block-memory read port
//   gcd_a/gcd_b/gcd_start       request to the external GCD core
//   gcd_done/gcd_result         reply from the GCD core
//   spi_data/spi_valid/spi_ready result stream to the SPI serializer
//   busy/done/pair_cnt          batch status
// slave  : the sequencer side (gcd_batch_seq)
// master : the environment side (memory, GCD core, serializer, controller)
interface gcd_batch_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              mem_ena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] gcd_a;
  logic [DATA_W-1:0] gcd_b;
  logic              gcd_start;
  logic              gcd_done;
  logic [DATA_W-1:0] gcd_result;
  logic [DATA_W-1:0] spi_data;
  logic              spi_valid;
  logic              spi_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pair_cnt;

  modport slave (
    input  start, mem_dout, gcd_done, gcd_result, spi_ready,
    output mem_ena, mem_addr, gcd_a, gcd_b, gcd_start,
           spi_data, spi_valid, busy, done, pair_cnt
  );

  modport master (
    output start, mem_dout, gcd_done, gcd_result, spi_ready,
    input  mem_ena, mem_addr, gcd_a, gcd_b, gcd_start,
           spi_data, spi_valid, busy, done, pair_cnt
  );
endinterface

// File: rtl/gcd_batch_seq.sv
// gcd_batch_seq - reads NUM_PAIRS operand pairs from block memory
// (A at 2k, B at 2k+1), computes gcd(A,B) through an external core
// (or directly as A|B when an operand is zero), and queues the results
// in a small FIFO that streams to an SPI serializer.
// Ports:
//   clk   system clock
//   rst_n asynchronous active-low reset
//   bus   gcd_batch_seq_if.slave (memory, GCD core, SPI stream, status)
module gcd_batch_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int NUM_PAIRS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gcd_batch_seq_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] K_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(NUM_PAIRS - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE, RD_A, WAIT_A, RD_B, WAIT_B, LAUNCH, WAIT_GCD, PUSH, DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_k;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic              r_done;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_zero_op;

  // Fullness is taken from the registered count, so a same-cycle pop never frees room for a push.
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_FULL);
  assign w_push    = (r_state == PUSH) && !w_full;
  assign w_pop     = !w_empty && bus.spi_ready;
  // B is still on mem_dout in WAIT_B; it is not yet in r_b.
  assign w_zero_op = (r_a == {DATA_W{1'b0}}) || (bus.mem_dout == {DATA_W{1'b0}});

  assign bus.mem_ena   = (r_state == RD_A) || (r_state == RD_B);
  assign bus.mem_addr  = bus.mem_ena ? {r_k[ADDR_W-2:0], (r_state == RD_B)} : {ADDR_W{1'b0}};
  assign bus.gcd_a     = r_a;
  assign bus.gcd_b     = r_b;
  assign bus.gcd_start = (r_state == LAUNCH);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.pair_cnt  = r_k;
  assign bus.spi_valid = !w_empty;
  assign bus.spi_data  = w_empty ? {DATA_W{1'b0}} : r_fifo[r_rd_ptr];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     w_state_nxt = bus.start ? RD_A : IDLE;
      RD_A:     w_state_nxt = WAIT_A;
      WAIT_A:   w_state_nxt = RD_B;
      RD_B:     w_state_nxt = WAIT_B;
      WAIT_B:   w_state_nxt = w_zero_op ? PUSH : LAUNCH;
      LAUNCH:   w_state_nxt = WAIT_GCD;
      WAIT_GCD: w_state_nxt = bus.gcd_done ? PUSH : WAIT_GCD;
      PUSH: begin
        if (w_full) begin
          w_state_nxt = PUSH;
        end else if (r_k == K_LAST) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RD_A;
        end
      end
      DRAIN:    w_state_nxt = w_empty ? IDLE : DRAIN;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Pair index, operand latches, result capture and the batch-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= {ADDR_W{1'b0}};
      r_a    <= {DATA_W{1'b0}};
      r_b    <= {DATA_W{1'b0}};
      r_res  <= {DATA_W{1'b0}};
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_empty;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_k <= {ADDR_W{1'b0}};
          end
        end
        WAIT_A: r_a <= bus.mem_dout;
        WAIT_B: begin
          r_b <= bus.mem_dout;
          // gcd(x,0) = x and gcd(0,0) = 0, both equal to A|B.
          if (w_zero_op) begin
            r_res <= r_a | bus.mem_dout;
          end
        end
        WAIT_GCD: begin
          if (bus.gcd_done) begin
            r_res <= bus.gcd_result;
          end
        end
        PUSH: begin
          if (w_push) begin
            r_k <= r_k + K_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy; drains in every FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the counted pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_res;
    end
  end

endmodule

// File: doc/gcd_batch_seq.md
GCD_BATCH_SEQ -- requirements
Module: gcd_batch_seq

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, operand/result width.
REQ-002 The module SHALL have parameter ADDR_W, default 5, memory address width.
REQ-003 The module SHALL have parameter NUM_PAIRS, default 16, operand pairs per batch; NUM_PAIRS*2 <= 2**ADDR_W.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, result buffer entries, a power of two.
REQ-005 The module SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 The module SHALL have ports as follows, one per line:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle batch request, e.g. debounced button
- mem_ena  out  1  block-memory read enable
- mem_addr  out  ADDR_W  block-memory address
- mem_dout  in  DATA_W  block-memory data, valid one cycle after mem_ena
- gcd_a, gcd_b  out  DATA_W  operands to the GCD core
- gcd_start  out  1  one-cycle GCD start pulse
- gcd_done  in  1  one-cycle GCD completion pulse
- gcd_result  in  DATA_W  GCD value, valid with gcd_done
- spi_data  out  DATA_W  FIFO head to the SPI serializer
- spi_valid  out  1  FIFO not empty
- spi_ready  in  1  serializer accepts spi_data this cycle
- busy  out  1  batch in progress
- done  out  1  one-cycle batch-complete pulse
- pair_cnt  out  ADDR_W  pairs completed in the current batch

Function
REQ-007 The FSM SHALL have the states IDLE, RD_A, WAIT_A, RD_B, WAIT_B, LAUNCH, WAIT_GCD, PUSH and DRAIN.
REQ-008 IDLE SHALL go to RD_A on start=1, clearing pair index k and pair_cnt; start SHALL be ignored in every other state.
REQ-009 RD_A SHALL drive mem_ena=1 and mem_addr=2k; WAIT_A SHALL latch mem_dout into A at the end of that cycle.
REQ-010 RD_B SHALL drive mem_ena=1 and mem_addr=2k+1; WAIT_B SHALL latch mem_dout into B; mem_ena SHALL be 0 in all other states.
REQ-011 After WAIT_B, if A=0 or B=0, the FSM SHALL skip the core: result=A|B (gcd(0,0)=0), next state PUSH.
REQ-012 After WAIT_B, if A and B are both nonzero, the next state SHALL be LAUNCH.
REQ-013 LAUNCH SHALL assert gcd_start for exactly one cycle and then go to WAIT_GCD.
REQ-014 gcd_a and gcd_b SHALL hold A and B stable from LAUNCH until the cycle after gcd_done.
REQ-015 WAIT_GCD SHALL latch gcd_result on gcd_done=1 and go to PUSH; there SHALL be no timeout.
REQ-016 PUSH SHALL write the result to the FIFO only when the FIFO is not full at that cycle, and otherwise stall in PUSH.
REQ-017 On a successful write, PUSH SHALL increment k and pair_cnt; it SHALL go to DRAIN if k+1=NUM_PAIRS, otherwise to RD_A.
REQ-018 DRAIN SHALL wait for the FIFO to be empty, then pulse done for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 FIFO: spi_valid = !empty; spi_data = head entry; a pop SHALL occur when spi_valid and spi_ready are both 1.
REQ-021 A pop while empty SHALL have no effect.
REQ-022 A simultaneous push and pop SHALL both occur with the count unchanged.
REQ-023 Fullness SHALL be evaluated before the same-cycle pop, so push stalls on a full FIFO even if a pop occurs that cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be FIFO_DEPTH+1 states wide.
REQ-025 The FIFO SHALL drain in every state, IDLE included.
REQ-026 Latency from start to the first spi_valid SHALL be 6 cycles plus GCD core latency, or 5 cycles for a zero-operand pair.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE.
REQ-028 While rst_n=0, k, pair_cnt, A, B, the FIFO pointers and the FIFO count SHALL be 0.
REQ-029 While rst_n=0, all outputs SHALL be 0, including spi_valid, busy, done, gcd_start and mem_ena.
REQ-030 Reset mid-batch SHALL discard the in-flight pair and all FIFO contents.
REQ-031 A gcd_done arriving after reset is released SHALL be ignored in IDLE.
REQ-032 Each batch SHALL restart from address 0.

Verification
REQ-033 Memory {48,18,...}, core latency 10, spi_ready=1 -> first spi_data=6; mem_addr sequence 0,1 precedes gcd_start.
REQ-034 Pair (0,35) -> gcd_start never asserted for that pair; 35 pushed; pair (0,0) -> 0 pushed.
REQ-035 spi_ready=0 for the whole batch -> exactly 4 results buffered, FSM stalls in PUSH with pair_cnt=4; releasing spi_ready -> all 16 results emerge in address order, then done pulses once.
REQ-036 FIFO holds 3 entries, push and pop in the same cycle -> count stays 3 and the output order is preserved.
REQ-037 start pulsed during busy -> ignored; pair_cnt continues without reset.
REQ-038 rst_n=0 during WAIT_GCD with 2 entries buffered -> spi_valid=0 immediately; next start processes pair 0 first.
